// File: rtl/tcp_pkg.sv
// Shared types for the TCP payload framer: channel ids, FIFO entry layout and
// the match-line priority helpers.
package tcp_pkg;

  typedef logic [1:0] chan_t;

  localparam chan_t CHAN_A = 2'd0;
  localparam chan_t CHAN_B = 2'd1;
  localparam chan_t CHAN_C = 2'd2;
  localparam chan_t CHAN_D = 2'd3;

  typedef struct packed {
    logic       last;
    chan_t      chan;
    logic [7:0] data;
  } fifo_ent_t;

  localparam int ENT_W = $bits(fifo_ent_t);

  // Lowest set bit wins (A > B > C > D); returns CHAN_A when nothing is set.
  function automatic chan_t onehot_to_chan(input logic [3:0] m);
    if (m[0])      return CHAN_A;
    else if (m[1]) return CHAN_B;
    else if (m[2]) return CHAN_C;
    else if (m[3]) return CHAN_D;
    else           return CHAN_A;
  endfunction

  function automatic logic multi_hot(input logic [3:0] m);
    return (m & (m - 4'd1)) != 4'd0;
  endfunction

endpackage

// File: rtl/tcp_byte_fifo.sv
// Synchronous FIFO with first-word-fall-through head; head reads zero while empty.
// Pointers carry one extra wrap bit so full/empty need no separate counter.
module tcp_byte_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 11
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem;
  logic [AW:0]                 wr_ptr, rd_ptr;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign rd_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLOCK)
    if (wr_en && !full) mem[wr_ptr[AW-1:0]] <= wr_data;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_en && !full) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/tcp_payload_framer.sv
// Frames matcher payload bytes into a tagged valid/ready stream with last-of-segment.
// Optional per-channel pop counters on byte_count when TCP_PAYLOAD_STATS_EN is defined.
module tcp_payload_framer
  import tcp_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int FLUSH_IDLE = 32,
  parameter int DROP_W     = 16
) (
  input  logic              CLOCK,
  input  logic              RESET_N,
  input  logic [7:0]        in_data,
  input  logic [3:0]        in_match,
  input  logic              newpkt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [7:0]        out_data,
  output logic [1:0]        out_chan,
  output logic              out_last,
  output logic [DROP_W-1:0] drop_count,
  output logic              overflow,
  output logic              multi_err
`ifdef TCP_PAYLOAD_STATS_EN
  ,
  output logic [127:0]      byte_count
`endif
);

  localparam int IW = (FLUSH_IDLE > 0) ? $clog2(FLUSH_IDLE + 1) : 1;

  logic          pend_valid;
  logic [7:0]    pend_data;
  chan_t         pend_chan;
  logic [IW-1:0] idle_cnt;

  logic      accept, flush_hit, push_req, pend_load, pend_clr;
  logic      fifo_full, fifo_empty, pop;
  chan_t     new_chan;
  fifo_ent_t push_ent, head;

  assign accept    = |in_match;
  assign new_chan  = onehot_to_chan(in_match);
  // Fires on the cycle the idle count would reach FLUSH_IDLE.
  assign flush_hit = (FLUSH_IDLE != 0) && (int'(idle_cnt) == FLUSH_IDLE - 1);

  always_comb begin
    push_req      = 1'b0;
    pend_load     = 1'b0;
    pend_clr      = 1'b0;
    push_ent.last = 1'b1;
    push_ent.chan = pend_chan;
    push_ent.data = pend_data;
    if (newpkt && pend_valid) begin
      push_req  = 1'b1;
      pend_load = accept;
      pend_clr  = !accept;
    end else if (accept && pend_valid) begin
      push_req      = 1'b1;
      push_ent.last = (pend_chan != new_chan);
      pend_load     = 1'b1;
    end else if (accept) begin
      pend_load = 1'b1;
    end else if (pend_valid && flush_hit) begin
      push_req = 1'b1;
      pend_clr = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      pend_chan  <= CHAN_A;
      idle_cnt   <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      multi_err  <= 1'b0;
    end else begin
      if (pend_load) begin
        pend_valid <= 1'b1;
        pend_data  <= in_data;
        pend_chan  <= new_chan;
      end else if (pend_clr) begin
        pend_valid <= 1'b0;
      end
      if (accept || newpkt)                   idle_cnt <= '0;
      else if (pend_valid && idle_cnt != '1)  idle_cnt <= idle_cnt + 1'b1;
      // Fullness is the start-of-cycle value; a same-cycle pop does not make room.
      if (push_req && fifo_full) begin
        overflow <= 1'b1;
        if (drop_count != '1) drop_count <= drop_count + 1'b1;
      end
      if (accept && multi_hot(in_match)) multi_err <= 1'b1;
    end
  end

  tcp_byte_fifo #(.DEPTH(DEPTH), .WIDTH(ENT_W)) u_fifo (
    .CLOCK   (CLOCK),
    .RESET_N (RESET_N),
    .wr_en   (push_req && !fifo_full),
    .wr_data (push_ent),
    .rd_en   (pop),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign out_data  = head.data;
  assign out_chan  = head.chan;
  assign out_last  = head.last;

`ifdef TCP_PAYLOAD_STATS_EN
  logic [3:0][31:0] chan_cnt;

  always_ff @(posedge CLOCK or negedge RESET_N) begin
    if (!RESET_N)  chan_cnt <= '0;
    else if (pop)  chan_cnt[out_chan] <= chan_cnt[out_chan] + 32'd1;
  end

  assign byte_count = chan_cnt;
`endif

endmodule

// File: tb/tb_tcp_payload_framer.sv
// Bench for tcp_payload_framer: vector table, hand sequences for flush/overflow/reset,
// and randomized traffic against a queue-based reference model.
module tb_tcp_payload_framer;

  localparam int DEPTH = 4;
  localparam int FLUSH = 4;

  logic        CLOCK = 1'b0;
  logic        RESET_N = 1'b0;
  logic [7:0]  in_data = '0;
  logic [3:0]  in_match = '0;
  logic        newpkt = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid, out_last, overflow, multi_err;
  logic [7:0]  out_data;
  logic [1:0]  out_chan;
  logic [15:0] drop_count;
  logic        nf_valid, nf_last, nf_ovf, nf_merr;
  logic [7:0]  nf_data;
  logic [1:0]  nf_chan;
  logic [15:0] nf_drop;

  always #5 CLOCK = ~CLOCK;

  tcp_payload_framer #(.DEPTH(DEPTH), .FLUSH_IDLE(FLUSH), .DROP_W(16)) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .in_data(in_data), .in_match(in_match),
    .newpkt(newpkt), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_chan(out_chan), .out_last(out_last), .drop_count(drop_count),
    .overflow(overflow), .multi_err(multi_err));

  // Second instance with the idle flush disabled; it drains continuously.
  tcp_payload_framer #(.DEPTH(16), .FLUSH_IDLE(0), .DROP_W(16)) dut_nf (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .in_data(in_data), .in_match(in_match),
    .newpkt(newpkt), .out_valid(nf_valid), .out_ready(1'b1), .out_data(nf_data),
    .out_chan(nf_chan), .out_last(nf_last), .drop_count(nf_drop),
    .overflow(nf_ovf), .multi_err(nf_merr));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: a held byte plus a bounded queue of {last,chan,data}.
  logic [10:0] mq[$];
  bit          mpv;
  logic [7:0]  mpd;
  logic [1:0]  mpc;
  int          midle, mdrop;
  bit          movf, mmerr;

  task automatic model_reset();
    mq.delete();
    mpv = 0; mpd = '0; mpc = '0; midle = 0; mdrop = 0; movf = 0; mmerr = 0;
  endtask

  task automatic model_step();
    bit acc, do_push, was_full, had_pend;
    logic [1:0] ch;
    logic [10:0] ent;
    acc = (in_match != 0);
    ch = 2'd0;
    for (int i = 3; i >= 0; i--) if (in_match[i]) ch = 2'(i);
    was_full = (mq.size() == DEPTH);
    had_pend = mpv;
    do_push = 0;
    ent = '0;
    if (acc && $countones(in_match) > 1) mmerr = 1;
    if (newpkt && mpv) begin
      do_push = 1; ent = {1'b1, mpc, mpd};
      mpv = acc; if (acc) begin mpd = in_data; mpc = ch; end
    end else if (acc && mpv) begin
      do_push = 1; ent = {mpc != ch, mpc, mpd};
      mpd = in_data; mpc = ch;
    end else if (acc) begin
      mpv = 1; mpd = in_data; mpc = ch;
    end else if (mpv && midle + 1 == FLUSH) begin
      do_push = 1; ent = {1'b1, mpc, mpd}; mpv = 0;
    end
    if (acc || newpkt) midle = 0;
    else if (had_pend) midle++;
    if (mq.size() > 0 && out_ready) void'(mq.pop_front());
    if (do_push) begin
      if (was_full) begin movf = 1; if (mdrop < 65535) mdrop++; end
      else mq.push_back(ent);
    end
  endtask

  task automatic model_cmp(input string tag);
    logic [10:0] h;
    h = (mq.size() > 0) ? mq[0] : 11'd0;
    chk({tag, ".valid"}, out_valid, mq.size() > 0);
    chk({tag, ".head"}, {out_last, out_chan, out_data}, h);
    chk({tag, ".drop"}, drop_count, mdrop);
    chk({tag, ".ovf"}, overflow, movf);
    chk({tag, ".merr"}, multi_err, mmerr);
  endtask

  task automatic tick(input string tag);
    model_step();
    @(posedge CLOCK);
    #1;
    model_cmp(tag);
  endtask

  task automatic drive(input logic [7:0] d, input logic [3:0] m, input logic np, input logic rdy);
    in_data = d; in_match = m; newpkt = np; out_ready = rdy;
  endtask

  task automatic do_reset();
    drive(8'h00, 4'h0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    #2;
    chk("rst.valid", out_valid, 1'b0);
    repeat (2) @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic [7:0] d; logic [3:0] m; logic np; logic rdy;
    logic ev; logic [7:0] ed; logic [1:0] ec; logic el;
  } vec_t;
  vec_t tv[$];

  initial begin
    model_reset();
    // Reset state.
    repeat (3) @(posedge CLOCK);
    #1;
    chk("reset.valid", out_valid, 1'b0);
    chk("reset.head", {out_last, out_chan, out_data}, 11'd0);
    chk("reset.drop", drop_count, 16'd0);
    chk("reset.ovf", overflow, 1'b0);
    chk("reset.merr", multi_err, 1'b0);
    RESET_N = 1'b1;

    // Basic framing, channel switch, multi-match (ready held high).
    tv.push_back('{8'h00, 4'h0, 1'b1, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0});
    tv.push_back('{8'h47, 4'h1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0});
    tv.push_back('{8'h45, 4'h1, 1'b0, 1'b1, 1'b1, 8'h47, 2'd0, 1'b0});
    tv.push_back('{8'h54, 4'h1, 1'b0, 1'b1, 1'b1, 8'h45, 2'd0, 1'b0});
    tv.push_back('{8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 8'h54, 2'd0, 1'b1});
    tv.push_back('{8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0});
    tv.push_back('{8'h10, 4'h1, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0});
    tv.push_back('{8'h11, 4'h1, 1'b0, 1'b1, 1'b1, 8'h10, 2'd0, 1'b0});
    tv.push_back('{8'h20, 4'h2, 1'b0, 1'b1, 1'b1, 8'h11, 2'd0, 1'b1});
    tv.push_back('{8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 8'h20, 2'd1, 1'b1});
    tv.push_back('{8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0});
    tv.push_back('{8'h55, 4'h6, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0});
    tv.push_back('{8'h00, 4'h0, 1'b1, 1'b1, 1'b1, 8'h55, 2'd1, 1'b1});
    tv.push_back('{8'h00, 4'h0, 1'b0, 1'b1, 1'b0, 8'h00, 2'd0, 1'b0});
    foreach (tv[i]) begin
      drive(tv[i].d, tv[i].m, tv[i].np, tv[i].rdy);
      tick("vec");
      chk($sformatf("vec%0d.valid", i), out_valid, tv[i].ev);
      chk($sformatf("vec%0d.head", i), {out_last, out_chan, out_data},
          tv[i].ev ? {tv[i].el, tv[i].ec, tv[i].ed} : 11'd0);
    end
    chk("multi.merr", multi_err, 1'b1);

    // Idle flush after exactly FLUSH idle cycles; disabled instance keeps holding.
    do_reset();
    drive(8'h20, 4'h1, 1'b0, 1'b0);
    tick("idle");
    drive(8'h00, 4'h0, 1'b0, 1'b0);
    for (int k = 1; k < FLUSH; k++) begin
      tick("idle");
      chk("idle.early", out_valid, 1'b0);
    end
    tick("idle");
    chk("idle.flush", {out_valid, out_last, out_chan, out_data}, {1'b1, 1'b1, 2'd0, 8'h20});
    chk("nf.held", nf_valid, 1'b0);
    drive(8'h00, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 8; k++) begin
      tick("idle");
      chk("nf.held", nf_valid, 1'b0);
    end
    drive(8'h00, 4'h0, 1'b1, 1'b1);
    tick("idle");
    chk("nf.release", {nf_valid, nf_last, nf_chan, nf_data}, {1'b1, 1'b1, 2'd0, 8'h20});

    // Overflow: 8 bytes + newpkt into a 4-deep FIFO with no consumer.
    do_reset();
    for (int k = 0; k < 8; k++) begin
      drive(8'h80 + 8'(k), 4'h1, 1'b0, 1'b0);
      tick("ovf");
    end
    drive(8'h00, 4'h0, 1'b1, 1'b0);
    tick("ovf");
    chk("ovf.drop", drop_count, 16'd4);
    chk("ovf.flag", overflow, 1'b1);
    drive(8'h00, 4'h0, 1'b0, 1'b1);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("ovf.drain%0d", k), {out_valid, out_last, out_chan, out_data},
          {1'b1, 1'b0, 2'd0, 8'h80 + 8'(k)});
      tick("ovf");
    end
    chk("ovf.empty", out_valid, 1'b0);

    // Randomized traffic against the model.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int r;
      logic [3:0] m;
      r = $urandom_range(0, 11);
      if (r < 4)       m = 4'h0;
      else if (r < 10) m = 4'h1 << $urandom_range(0, 3);
      else             m = 4'($urandom_range(0, 15));
      if (n % 50 > 42) m = 4'h0;
      drive(8'($urandom), m, ($urandom_range(0, 7) == 0), ($urandom_range(0, 1) == 1));
      tick("rand");
    end

    // Reset mid-stream with three entries queued and a held byte.
    do_reset();
    drive(8'hA1, 4'h1, 1'b0, 1'b0); tick("mid");
    drive(8'hA2, 4'h1, 1'b0, 1'b0); tick("mid");
    drive(8'hA3, 4'h3, 1'b0, 1'b0); tick("mid");
    drive(8'hA4, 4'h1, 1'b0, 1'b0); tick("mid");
    chk("mid.pre.merr", multi_err, 1'b1);
    drive(8'h00, 4'h0, 1'b0, 1'b0);
    RESET_N = 1'b0;
    #2;
    chk("mid.valid", out_valid, 1'b0);
    chk("mid.head", {out_last, out_chan, out_data}, 11'd0);
    chk("mid.drop", drop_count, 16'd0);
    chk("mid.ovf", overflow, 1'b0);
    chk("mid.merr", multi_err, 1'b0);
    @(posedge CLOCK);
    #1;
    RESET_N = 1'b1;
    model_reset();
    drive(8'h99, 4'h2, 1'b0, 1'b0); tick("post");
    chk("post.hold", out_valid, 1'b0);
    drive(8'h00, 4'h0, 1'b1, 1'b0); tick("post");
    chk("post.head", {out_valid, out_last, out_chan, out_data}, {1'b1, 1'b1, 2'd1, 8'h99});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
